// File: rtl/cache_burst_adapter_pkg.sv
// Shared memory-side types for the cache burst adapter: line/beat widths,
// state encoding and a beat-insert helper.
package cache_mem_types;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
  typedef logic [1:0]             beat_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } adapter_state_t;

  // Returns line with beat slot idx replaced by beat.
  function automatic line_t set_beat(line_t line, beat_idx_t idx, beat_t beat);
    line_t r;
    r = line;
    r[BURST_WIDTH*idx +: BURST_WIDTH] = beat;
    return r;
  endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// One cache line of storage: whole-line load, single-beat write at an index,
// and a combinational beat read at the same index.
module burst_line_buffer
  import cache_mem_types::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  input  logic                   wr_i,
  input  logic [1:0]             idx_i,
  input  logic [BURST_WIDTH-1:0] beat_i,
  output logic [BURST_WIDTH-1:0] beat_o,
  output logic [LINE_WIDTH-1:0]  line_o
);

  logic [LINE_WIDTH-1:0] buf_q;

  // NOTE: this storage is reset on purpose; burst_o must read 0 straight out of reset.
  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (load_i) begin
      buf_q <= line_i;
    end else if (wr_i) begin
      buf_q[BURST_WIDTH*idx_i +: BURST_WIDTH] <= beat_i;
    end
  end

  assign beat_o = buf_q[BURST_WIDTH*idx_i +: BURST_WIDTH];
  assign line_o = buf_q;

endmodule

// File: rtl/cache_burst_adapter.sv
// Converts whole-line cache reads/writes into 4-beat memory bursts.
// Optional per-beat watchdog enabled by defining BURST_ADAPTER_TIMEOUT_EN.
module cache_burst_adapter
  import cache_mem_types::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  output logic                   err_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  adapter_state_t        state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  buf_load, buf_wr;
  logic [LINE_WIDTH-1:0] buf_line;
  logic [BURST_WIDTH-1:0] buf_beat;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^address_i[4:0];

  burst_line_buffer u_buf (
    .clk    (clk),
    .rst    (rst),
    .load_i (buf_load),
    .line_i (line_i),
    .wr_i   (buf_wr),
    .idx_i  (k_q),
    .beat_i (burst_i),
    .beat_o (buf_beat),
    .line_o (buf_line)
  );

`ifdef BURST_ADAPTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    addr_d   = addr_q;
    line_d   = line_q;
    buf_load = 1'b0;
    buf_wr   = 1'b0;
`ifdef BURST_ADAPTER_TIMEOUT_EN
    wd_d     = '0;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (write_i) begin
          state_d  = WR;
          buf_load = 1'b1;
          addr_d   = {address_i[31:5], 5'b0};
        end else if (read_i) begin
          state_d = RD;
          addr_d  = {address_i[31:5], 5'b0};
        end
      end
      RD: begin
        if (resp_i) begin
          buf_wr = 1'b1;
          k_d    = k_q + 2'd1;
          // line_o is published only on read completion, including the final beat.
          if (k_q == 2'd3) begin
            state_d = DONE;
            line_d  = set_beat(buf_line, k_q, burst_i);
          end
        end
`ifdef BURST_ADAPTER_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          k_d     = '0;
          line_d  = buf_line;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      WR: begin
        if (resp_i) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = DONE;
        end
`ifdef BURST_ADAPTER_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          k_d     = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      DONE: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_o    = (state_q == RD);
  assign write_o   = (state_q == WR);
  assign resp_o    = (state_q == DONE);
  assign burst_o   = buf_beat;
  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule

// File: tb/tb_cache_burst_adapter.sv
// Directed bench for cache_burst_adapter with a scoreboard of expected
// line_o values checked on each resp_o.
module tb_cache_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic         err_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int total = 0;
  int bad   = 0;
  logic [255:0] exp_q[$];
  logic [255:0] line_model;

  cache_burst_adapter #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .err_o     (err_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the cycle resp_o is expected; pops the scoreboard.
  task automatic expect_resp(input string tag);
    logic [255:0] e;
    check({tag, "_resp"}, 256'(resp_o), 256'(1'b1));
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_line"}, line_o, e);
    end
  endtask

  // Drives four beats, one per cycle, while the DUT is in RD.
  task automatic feed_read(input string tag, input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0] b[4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_read_o"}, 256'(read_o), 256'(1'b1));
      resp_i  = 1'b1;
      burst_i = b[i];
      tick();
    end
    resp_i  = 1'b0;
    burst_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [63:0]  s[4];
    logic [255:0] wline;
    int           seen;

    rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    #2;
    do_reset();

    check("rst_line_o",    line_o,            256'd0);
    check("rst_burst_o",   256'(burst_o),     256'd0);
    check("rst_address_o", 256'(address_o),   256'd0);
    check("rst_read_o",    256'(read_o),      256'd0);
    check("rst_write_o",   256'(write_o),     256'd0);
    check("rst_resp_o",    256'(resp_o),      256'd0);
    check("rst_err_o",     256'(err_o),       256'd0);

`ifdef BURST_ADAPTER_TIMEOUT_EN
    // One beat then silence: watchdog aborts 16 cycles after the last beat.
    address_i = 32'h0000_4000;
    read_i    = 1'b1;
    tick();
    read_i    = 1'b0;
    resp_i    = 1'b1;
    burst_i   = 64'hAAAA_BBBB_CCCC_DDDD;
    exp_q.push_back({192'd0, 64'hAAAA_BBBB_CCCC_DDDD});
    tick();
    resp_i  = 1'b0;
    burst_i = '0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) check("to_no_resp", 256'(resp_o), 256'd0);
    end
    expect_resp("to");
    check("to_err", 256'(err_o), 256'd1);
    for (int i = 0; i < 3; i++) tick();
    check("to_err_sticky", 256'(err_o), 256'd1);
    check("to_idle",       256'(read_o), 256'd0);
    do_reset();
    check("to_err_cleared", 256'(err_o), 256'd0);
`endif

    // Read, zero-wait memory.
    address_i = 32'h0000_1234;
    read_i    = 1'b1;
    line_model = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    exp_q.push_back(line_model);
    tick();
    check("rd_address_o", 256'(address_o), 256'h0000_1220);
    check("rd_no_resp",   256'(resp_o),    256'd0);
    feed_read("rd", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    expect_resp("rd");
    check("rd_done_read_o", 256'(read_o), 256'd0);
    read_i = 1'b0;
    tick();
    check("rd_resp_one_cycle", 256'(resp_o), 256'd0);
    tick();

    // Write with resp_i every third cycle.
    s[0] = 64'h0123_4567_89AB_CDEF;
    s[1] = 64'hFEDC_BA98_7654_3210;
    s[2] = 64'h0F1E_2D3C_4B5A_6978;
    s[3] = 64'h8796_A5B4_C3D2_E1F0;
    wline     = {s[3], s[2], s[1], s[0]};
    line_i    = wline;
    address_i = 32'h8000_00FF;
    write_i   = 1'b1;
    exp_q.push_back(line_model);
    tick();
    check("wr_address_o", 256'(address_o), 256'h8000_00E0);
    line_i = '1;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 3; g++) begin
        check("wr_write_o", 256'(write_o), 256'd1);
        check("wr_burst_o", 256'(burst_o), 256'(s[b]));
        resp_i = (g == 2);
        tick();
      end
    end
    resp_i = 1'b0;
    check("wr_write_o_drop", 256'(write_o), 256'd0);
    expect_resp("wr");
    write_i = 1'b0;
    tick();
    tick();

    // Simultaneous read and write: write wins.
    line_i  = {4{64'hDEAD_BEEF_0000_0001}};
    read_i  = 1'b1;
    write_i = 1'b1;
    exp_q.push_back(line_model);
    tick();
    for (int b = 0; b < 4; b++) begin
      check("both_write_o", 256'(write_o), 256'd1);
      check("both_read_o",  256'(read_o),  256'd0);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    check("both_read_o_done", 256'(read_o), 256'd0);
    expect_resp("both");
    read_i  = 1'b0;
    write_i = 1'b0;
    tick();
    tick();

    // Async reset in the middle of a read burst.
    address_i = 32'h00AB_CDEF;
    read_i    = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      resp_i  = 1'b1;
      burst_i = 64'h5555_0000_0000_0000 | 64'(b);
      tick();
    end
    resp_i = 1'b0;
    check("rstmid_pre_read_o", 256'(read_o), 256'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_read_o", 256'(read_o), 256'd0);
    check("rstmid_line_o", line_o, 256'd0);
    check("rstmid_addr_o", 256'(address_o), 256'd0);
    read_i = 1'b0;
    #2;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_o) seen++;
    end
    check("rstmid_no_resp", 256'(seen), 256'd0);

    // Fresh read after reset: beat index restarts at 0.
    address_i  = 32'h0000_0040;
    read_i     = 1'b1;
    line_model = {64'hD0D0_D0D0_D0D0_D0D0, 64'hC0C0_C0C0_C0C0_C0C0,
                  64'hB0B0_B0B0_B0B0_B0B0, 64'hA0A0_A0A0_A0A0_A0A0};
    exp_q.push_back(line_model);
    tick();
    feed_read("rd2", 64'hA0A0_A0A0_A0A0_A0A0, 64'hB0B0_B0B0_B0B0_B0B0,
              64'hC0C0_C0C0_C0C0_C0C0, 64'hD0D0_D0D0_D0D0_D0D0);
    expect_resp("rd2");

    // read_i held through DONE: second read; spurious resp_i in DONE/IDLE ignored.
    line_model = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                  64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    exp_q.push_back(line_model);
    resp_i  = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    check("b2b_idle_read_o", 256'(read_o), 256'd0);
    check("b2b_idle_resp_o", 256'(resp_o), 256'd0);
    tick();
    resp_i  = 1'b0;
    check("b2b_rd_read_o", 256'(read_o), 256'd1);
    feed_read("b2b", 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
              64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404);
    expect_resp("b2b");
    read_i = 1'b0;
    tick();
    tick();
    check("end_idle", 256'({read_o, write_o, resp_o}), 256'd0);
`ifndef BURST_ADAPTER_TIMEOUT_EN
    check("end_err_o", 256'(err_o), 256'd0);
`endif
    check("sb_drained", 256'(exp_q.size()), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
